// File: rtl/window_accumulator_pkg.sv
// Shared types and elaboration helpers for the window accumulator.
package window_accumulator_pkg;

   // Two-state controller: gather WINDOW tokens, then offer one sum.
   typedef enum logic [0:0] {
      ST_ACC  = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   // Ceiling log2 for elaboration-time sizing (bounded loop).
   function automatic int clog2_int(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
         end
      end
      return result;
   endfunction

   // Group counter width, never narrower than one bit (WINDOW=1 still needs a register).
   function automatic int cnt_width(input int window);
      return (clog2_int(window) < 1) ? 1 : clog2_int(window);
   endfunction

   // The output must hold WINDOW full-scale tokens without wrapping.
   function automatic bit out_w_ok(input int data_w, input int window, input int out_w);
      return (window >= 1) && (window <= 256) && (out_w >= data_w + clog2_int(window));
   endfunction

endpackage

// File: rtl/window_accumulator.sv
// Block-sum decimator: adds each non-overlapping group of WINDOW tokens and
// writes one widened sum downstream. Reads and the write never share a cycle.
module window_accumulator
   import window_accumulator_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int WINDOW = 4,
   parameter int OUT_W  = 18
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in0_empty,
   input  logic [DATA_W-1:0] in0,
   output logic              in0_rd,
   input  logic              out0_full,
   output logic [OUT_W-1:0]  out0,
   output logic              out0_wr
);

   localparam int CNT_W = cnt_width(WINDOW);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

   // Reject parameter sets whose sum could wrap.
   if (!out_w_ok(DATA_W, WINDOW, OUT_W)) begin : g_param_check
      $error("window_accumulator: OUT_W too narrow or WINDOW outside 1..256");
   end

   state_t           state_reg;
   logic [OUT_W-1:0] acc_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [OUT_W-1:0] sum_reg;
   logic [OUT_W-1:0] in0_ext;

   assign in0_ext = OUT_W'(in0);
   assign out0    = sum_reg;

   // Handshake decode: read only while gathering, write only while emitting, neither in reset.
   always_comb begin
      in0_rd  = 1'b0;
      out0_wr = 1'b0;
      if (reset) begin
         if (state_reg == ST_ACC) begin
            in0_rd = !in0_empty;
         end else begin
            out0_wr = !out0_full;
         end
      end
   end

   // Accumulate on read edges; the last token of a group moves the total into sum and waits for a write.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg <= ST_ACC;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         sum_reg   <= '0;
      end else begin
         case (state_reg)
            ST_ACC: begin
               if (in0_rd) begin
                  if (cnt_reg == CNT_LAST) begin
                     sum_reg   <= acc_reg + in0_ext;
                     acc_reg   <= '0;
                     cnt_reg   <= '0;
                     state_reg <= ST_EMIT;
                  end else begin
                     acc_reg <= acc_reg + in0_ext;
                     cnt_reg <= cnt_reg + CNT_W'(1);
                  end
               end
            end
            ST_EMIT: begin
               if (out0_wr) begin
                  state_reg <= ST_ACC;
               end
            end
            default: begin
               state_reg <= ST_ACC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_window_accumulator.sv
// Bench for window_accumulator: directed table for WINDOW=4, a hand sequence
// for WINDOW=1, then random traffic against a token-queue reference model.
module tb_window_accumulator;

   localparam int DATA_W = 16;
   localparam int OUT_W  = 18;

   typedef struct {
      logic              rst_n;
      logic              empty;
      logic [DATA_W-1:0] din;
      logic              full;
      logic              exp_rd;
      logic              exp_wr;
      logic [OUT_W-1:0]  exp_out;
   } vec_t;

   logic              clk;
   logic              rst_n;
   logic              empty;
   logic [DATA_W-1:0] din;
   logic              full;
   logic              rd4, wr4, rd1, wr1;
   logic [OUT_W-1:0]  out4, out1;

   int n_vec;
   int n_err;

   // Reference state: tokens of the open group, pending flag, last sum.
   logic [DATA_W-1:0] q4[$];
   logic [DATA_W-1:0] q1[$];
   bit                m_pend[2];
   logic [OUT_W-1:0]  m_sum[2];

   vec_t tab[$];

   window_accumulator #(.DATA_W(DATA_W), .WINDOW(4), .OUT_W(OUT_W)) u_win4 (
      .clock(clk), .reset(rst_n), .in0_empty(empty), .in0(din), .in0_rd(rd4),
      .out0_full(full), .out0(out4), .out0_wr(wr4)
   );

   window_accumulator #(.DATA_W(DATA_W), .WINDOW(1), .OUT_W(OUT_W)) u_win1 (
      .clock(clk), .reset(rst_n), .in0_empty(empty), .in0(din), .in0_rd(rd1),
      .out0_full(full), .out0(out1), .out0_wr(wr1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic e, input logic [DATA_W-1:0] d,
                               input logic f, input logic xrd, input logic xwr,
                               input logic [OUT_W-1:0] xo);
      vec_t v;
      v.rst_n = r; v.empty = e; v.din = d; v.full = f;
      v.exp_rd = xrd; v.exp_wr = xwr; v.exp_out = xo;
      return v;
   endfunction

   function automatic logic [OUT_W-1:0] qsum(input logic [DATA_W-1:0] q[$]);
      int unsigned t;
      t = 0;
      foreach (q[i]) t += q[i];
      return OUT_W'(t);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the reference of instance k across one rising edge.
   task automatic model_step(input int k, input int window);
      if (!rst_n) begin
         if (k == 0) q4.delete(); else q1.delete();
         m_pend[k] = 1'b0;
         m_sum[k]  = '0;
      end else if (m_pend[k]) begin
         if (!full) m_pend[k] = 1'b0;
      end else if (!empty) begin
         if (k == 0) begin
            q4.push_back(din);
            if (q4.size() == window) begin
               m_sum[k] = qsum(q4); q4.delete(); m_pend[k] = 1'b1;
            end
         end else begin
            q1.push_back(din);
            if (q1.size() == window) begin
               m_sum[k] = qsum(q1); q1.delete(); m_pend[k] = 1'b1;
            end
         end
      end
   endtask

   // One clock: drive, settle, compare (table or model), then step the models.
   task automatic cycle(input vec_t v, input bit use_tab4, input bit use_tab1);
      logic xrd, xwr;
      @(negedge clk);
      rst_n = v.rst_n; empty = v.empty; din = v.din; full = v.full;
      #1;
      if (use_tab4) begin
         chk("rd4", 32'(rd4), 32'(v.exp_rd));
         chk("wr4", 32'(wr4), 32'(v.exp_wr));
         chk("out4", 32'(out4), 32'(v.exp_out));
      end else begin
         xrd = rst_n && !m_pend[0] && !empty;
         xwr = rst_n && m_pend[0] && !full;
         chk("rd4_model", 32'(rd4), 32'(xrd));
         chk("wr4_model", 32'(wr4), 32'(xwr));
         chk("out4_model", 32'(out4), 32'(m_sum[0]));
      end
      if (use_tab1) begin
         chk("rd1", 32'(rd1), 32'(v.exp_rd));
         chk("wr1", 32'(wr1), 32'(v.exp_wr));
         chk("out1", 32'(out1), 32'(v.exp_out));
      end else begin
         xrd = rst_n && !m_pend[1] && !empty;
         xwr = rst_n && m_pend[1] && !full;
         chk("rd1_model", 32'(rd1), 32'(xrd));
         chk("wr1_model", 32'(wr1), 32'(xwr));
         chk("out1_model", 32'(out1), 32'(m_sum[1]));
      end
      if (wr4 === 1'b1) $display("u_win4 write sum=%0d (0x%0h)", out4, out4);
      if (wr1 === 1'b1) $display("u_win1 write sum=%0d (0x%0h)", out1, out1);
      model_step(0, 4);
      model_step(1, 1);
   endtask

   initial begin
      vec_t rv;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0; empty = 1'b1; din = '0; full = 1'b0;
      m_pend[0] = 1'b0; m_pend[1] = 1'b0;
      m_sum[0] = '0; m_sum[1] = '0;
      repeat (2) @(posedge clk);

      // Reset state, then 2,4,6,8 -> 20
      tab.push_back(mk(0, 0, 16'd5, 0, 0, 0, 18'd0));
      tab.push_back(mk(1, 0, 16'd2, 0, 1, 0, 18'd0));
      tab.push_back(mk(1, 0, 16'd4, 0, 1, 0, 18'd0));
      tab.push_back(mk(1, 0, 16'd6, 0, 1, 0, 18'd0));
      tab.push_back(mk(1, 0, 16'd8, 0, 1, 0, 18'd0));
      tab.push_back(mk(1, 0, 16'hFFFF, 0, 0, 1, 18'd20));
      // Four full-scale tokens -> 0x3FFFC, then 1,1,1,1 -> 4
      for (int i = 0; i < 4; i++) tab.push_back(mk(1, 0, 16'hFFFF, 0, 1, 0, 18'd20));
      tab.push_back(mk(1, 0, 16'd1, 0, 0, 1, 18'h3FFFC));
      for (int i = 0; i < 4; i++) tab.push_back(mk(1, 0, 16'd1, 0, 1, 0, 18'h3FFFC));
      tab.push_back(mk(1, 1, 16'd0, 0, 0, 1, 18'd4));
      // Backpressure on 10,20,30,40 -> 100 held for 5 cycles, one write
      tab.push_back(mk(1, 0, 16'd10, 0, 1, 0, 18'd4));
      tab.push_back(mk(1, 0, 16'd20, 0, 1, 0, 18'd4));
      tab.push_back(mk(1, 0, 16'd30, 0, 1, 0, 18'd4));
      tab.push_back(mk(1, 0, 16'd40, 1, 1, 0, 18'd4));
      for (int i = 0; i < 5; i++) tab.push_back(mk(1, 0, 16'd50, 1, 0, 0, 18'd100));
      tab.push_back(mk(1, 0, 16'd50, 0, 0, 1, 18'd100));
      tab.push_back(mk(1, 1, 16'd50, 0, 0, 0, 18'd100));
      // Empty gaps: 5,_,_,7,_,9,_,_,_,11 -> 32
      tab.push_back(mk(1, 0, 16'd5, 0, 1, 0, 18'd100));
      tab.push_back(mk(1, 1, 16'd77, 0, 0, 0, 18'd100));
      tab.push_back(mk(1, 1, 16'd77, 0, 0, 0, 18'd100));
      tab.push_back(mk(1, 0, 16'd7, 0, 1, 0, 18'd100));
      tab.push_back(mk(1, 1, 16'd77, 0, 0, 0, 18'd100));
      tab.push_back(mk(1, 0, 16'd9, 0, 1, 0, 18'd100));
      for (int i = 0; i < 3; i++) tab.push_back(mk(1, 1, 16'd77, 0, 0, 0, 18'd100));
      tab.push_back(mk(1, 0, 16'd11, 0, 1, 0, 18'd100));
      tab.push_back(mk(1, 1, 16'd0, 0, 0, 1, 18'd32));
      // Reset mid-window after 3,3; then 1,2,3,4 -> 10
      tab.push_back(mk(1, 0, 16'd3, 0, 1, 0, 18'd32));
      tab.push_back(mk(1, 0, 16'd3, 0, 1, 0, 18'd32));
      tab.push_back(mk(0, 0, 16'd3, 0, 0, 0, 18'd32));
      tab.push_back(mk(1, 0, 16'd1, 0, 1, 0, 18'd0));
      tab.push_back(mk(1, 0, 16'd2, 0, 1, 0, 18'd0));
      tab.push_back(mk(1, 0, 16'd3, 0, 1, 0, 18'd0));
      tab.push_back(mk(1, 0, 16'd4, 0, 1, 0, 18'd0));
      tab.push_back(mk(1, 1, 16'd0, 0, 0, 1, 18'd10));
      // Reset while stalled in EMIT: no write, back to gathering with sum cleared
      for (int i = 0; i < 4; i++) tab.push_back(mk(1, 0, 16'd1, 0, 1, 0, 18'd10));
      tab.push_back(mk(1, 1, 16'd0, 1, 0, 0, 18'd4));
      tab.push_back(mk(0, 1, 16'd0, 1, 0, 0, 18'd4));
      tab.push_back(mk(1, 1, 16'd0, 0, 0, 0, 18'd0));
      tab.push_back(mk(1, 0, 16'd7, 0, 1, 0, 18'd0));

      foreach (tab[i]) cycle(tab[i], 1'b1, 1'b0);

      // WINDOW=1: 7 then 9, alternating read and write cycles
      cycle(mk(0, 1, 16'd0, 0, 0, 0, 18'd0), 1'b0, 1'b0);
      tab.delete();
      tab.push_back(mk(1, 0, 16'd7, 0, 1, 0, 18'd0));
      tab.push_back(mk(1, 0, 16'd9, 0, 0, 1, 18'd7));
      tab.push_back(mk(1, 0, 16'd9, 0, 1, 0, 18'd7));
      tab.push_back(mk(1, 1, 16'd0, 0, 0, 1, 18'd9));
      tab.push_back(mk(1, 1, 16'd0, 0, 0, 0, 18'd9));
      foreach (tab[i]) cycle(tab[i], 1'b0, 1'b1);

      // Random traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         rv.rst_n = ($urandom_range(0, 199) != 0);
         rv.empty = ($urandom_range(0, 9) < 4);
         rv.full  = ($urandom_range(0, 9) < 3);
         rv.din   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         rv.exp_rd = 1'b0; rv.exp_wr = 1'b0; rv.exp_out = '0;
         cycle(rv, 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/window_accumulator.md
Name: window_accumulator

Overview:
- Streaming actor placed directly downstream of the left-shift stage.
- Consumes its 16-bit token stream through the same empty/rd and full/wr FIFO handshake.
- Sums each non-overlapping group of WINDOW consecutive tokens and emits one widened sum token per group.
- Provides block-sum decimation for the toy dataflow chain.

Parameters:
- DATA_W, 16, input token width.
- WINDOW, 4, tokens per group; legal range 1..256.
- OUT_W, 18, output width; must be >= DATA_W + clog2(WINDOW); checked by elaboration assertion.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset (sampled on rising clock edge; 0 = reset).
- in0_empty  in  1  upstream FIFO empty flag.
- in0  in  DATA_W  upstream token (show-ahead: valid whenever in0_empty=0).
- in0_rd  out  1  read strobe; token consumed on the edge where in0_rd=1.
- out0_full  in  1  downstream FIFO full flag.
- out0  out  OUT_W  sum token, registered.
- out0_wr  out  1  write strobe; token accepted on the edge where out0_wr=1.

Behaviour:
- Arithmetic is unsigned. in0 is zero-extended to OUT_W. No overflow is possible under the OUT_W rule.
- State machine has two states, ACC and EMIT. Internal registers: acc (OUT_W), cnt (clog2(WINDOW) bits, min 1), sum (OUT_W, drives out0).
- Reset (reset=0 at an edge):
  - state=ACC, acc=0, cnt=0, sum=0.
  - in0_rd=0 and out0_wr=0 combinationally whenever reset=0.
  - Reset mid-window discards partial acc.
  - Reset in EMIT drops the pending sum; no write occurs.
- ACC state:
  - in0_rd = !in0_empty (combinational); out0_wr=0.
  - On a read edge with cnt<WINDOW-1: acc<=acc+in0, cnt<=cnt+1.
  - On a read edge with cnt==WINDOW-1: sum<=acc+in0, acc<=0, cnt<=0, state<=EMIT.
  - in0_empty=1: all registers hold; empty gaps of any length do not affect the result.
- EMIT state:
  - in0_rd=0; out0_wr = !out0_full (combinational); out0=sum.
  - On a write edge: state<=ACC.
  - out0_full=1: hold EMIT, sum stable, no reads. Backpressure is unbounded.
- out0 always shows sum, never X. It holds the last emitted value while in ACC.
- Latency: sum presented on out0 with out0_wr possible in the cycle after the edge that reads the group's last token.
- Throughput: at most one output per WINDOW+1 cycles. Reads and the write never occur in the same cycle.
- WINDOW=1: each token passes through zero-extended, at one token per 2 cycles.
- A token is never read without being counted, and a sum is never written twice.

Decomposition:
- Shared package window_accumulator_pkg holds:
  - state enum typedef (ST_ACC, ST_EMIT);
  - localparam helper for CNT_W = max(1, clog2(WINDOW));
  - the OUT_W legality function.
- No sub-module: a single flat module with one sequential process plus a combinational handshake decode.

Test Plan:
1. WINDOW=4; tokens 2,4,6,8 back-to-back, out0_full=0 -> in0_rd high 4 cycles, then out0_wr=1 for 1 cycle with out0=20 (0x00014), then in0_rd resumes.
2. Max data: four tokens 0xFFFF -> out0=0x3FFFC, no wrap. Next group 1,1,1,1 -> out0=4, confirming acc cleared.
3. Backpressure: group 10,20,30,40 completes while out0_full=1 for 5 cycles -> out0_wr=0 and in0_rd=0 throughout, out0=100 stable. out0_wr=1 in the first cycle out0_full=0; exactly one write.
4. Empty gaps: tokens 5,_,_,7,_,9,_,_,_,11 (in0_empty=1 at '_') -> single output 32; in0_rd never high while in0_empty=1.
5. Reset mid-window: read 3 and 3, pull reset=0 for 1 cycle, then feed 1,2,3,4 -> out0=10. Reset in EMIT with out0_full=1 -> no write, returns to ACC, out0=0.
6. WINDOW=1 build: tokens 7,9 -> out0=7 then 9, each written once, alternating read/write cycles.
